mdu: RTL and testbench

- Multiply/divide unit in the EX stage of the 5-stage MIPS pipeline.
- Consumes the forwarded rs value and the rt value or extended immediate, the same operand bus the immediate extender feeds.
- Owns the HI/LO registers and executes MULT/MULTU/DIV/DIVU with fixed multi-cycle latency.
- Serves MTHI/MTLO/MFHI/MFLO and exports start/busy to the hazard unit, which stalls D-stage MDU instructions.

---
 rtl/mdu.sv | 116 +++++++++++
 tb/tb_mdu.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mdu.sv
// Multiply/divide unit for the EX stage: owns HI/LO, runs MULT/MULTU/DIV/DIVU
// with fixed latency. Optional MADD/MADDU/MSUB/MSUBU when MDU_MACC_EN is defined.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        req,
  output logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mdu_out
);

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MFHI  = 4'd7,
    OP_MFLO  = 4'd8,
    OP_MADD  = 4'd9,
    OP_MADDU = 4'd10,
    OP_MSUB  = 4'd11,
    OP_MSUBU = 4'd12
  } mdu_op_e;

  localparam int CMAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  logic [CW-1:0] count;
  logic [31:0]   res_hi, res_lo;
  logic [63:0]   res_next;
  logic          launch_op;
  logic          mul_class;

  logic [63:0] prod_s, prod_u;
  logic        div_signed;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, quo, rem;

  assign prod_s = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
  assign prod_u = {32'b0, src_a} * {32'b0, src_b};

  // Signed divide runs on magnitudes so 0x80000000 / -1 wraps to 0x80000000.
  assign div_signed = (mdu_op == OP_DIV);
  assign a_mag = (div_signed && src_a[31]) ? -src_a : src_a;
  assign b_mag = (div_signed && src_b[31]) ? -src_b : src_b;
  assign q_mag = a_mag / b_mag;
  assign r_mag = a_mag % b_mag;
  assign quo   = (div_signed && (src_a[31] ^ src_b[31])) ? -q_mag : q_mag;
  assign rem   = (div_signed && src_a[31]) ? -r_mag : r_mag;

  always_comb begin
    res_next  = {hi, lo};
    launch_op = 1'b0;
    mul_class = 1'b0;
    case (mdu_op)
      OP_MULT:  begin res_next = prod_s; launch_op = 1'b1; mul_class = 1'b1; end
      OP_MULTU: begin res_next = prod_u; launch_op = 1'b1; mul_class = 1'b1; end
      OP_DIV, OP_DIVU: begin
        launch_op = 1'b1;
        if (src_b != 32'd0) res_next = {rem, quo};
      end
`ifdef MDU_MACC_EN
      OP_MADD:  begin res_next = {hi, lo} + prod_s; launch_op = 1'b1; mul_class = 1'b1; end
      OP_MADDU: begin res_next = {hi, lo} + prod_u; launch_op = 1'b1; mul_class = 1'b1; end
      OP_MSUB:  begin res_next = {hi, lo} - prod_s; launch_op = 1'b1; mul_class = 1'b1; end
      OP_MSUBU: begin res_next = {hi, lo} - prod_u; launch_op = 1'b1; mul_class = 1'b1; end
`endif
      default: ;
    endcase
  end

  assign start = launch_op && !req && !busy;

  always_comb begin
    mdu_out = 32'd0;
    if (mdu_op == OP_MFHI) mdu_out = hi;
    else if (mdu_op == OP_MFLO) mdu_out = lo;
  end

  // While busy every new op (MT* included) is ignored; the result lands when count hits 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi     <= 32'd0;
      lo     <= 32'd0;
      busy   <= 1'b0;
      count  <= '0;
      res_hi <= 32'd0;
      res_lo <= 32'd0;
    end else if (busy) begin
      count <= count - CW'(1);
      if (count == CW'(1)) begin
        hi   <= res_hi;
        lo   <= res_lo;
        busy <= 1'b0;
      end
    end else if (start) begin
      {res_hi, res_lo} <= res_next;
      count <= mul_class ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
      busy  <= 1'b1;
    end else if (!req) begin
      if (mdu_op == OP_MTHI) hi <= src_a;
      if (mdu_op == OP_MTLO) lo <= src_a;
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Randomized self-checking bench for mdu against a cycle-count reference model.
// Define MDU_MACC_EN for both DUT and bench to cover the accumulate ops.
module tb_mdu;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  mdu_op;
  logic [31:0] src_a, src_b;
  logic        req;
  logic        start, busy;
  logic [31:0] hi, lo, mdu_out;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  int          m_left;

  mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .mdu_op(mdu_op), .src_a(src_a), .src_b(src_b),
    .req(req), .start(start), .busy(busy), .hi(hi), .lo(lo), .mdu_out(mdu_out)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic bit is_launch(input logic [3:0] op);
`ifdef MDU_MACC_EN
    return (op >= 4'd1 && op <= 4'd4) || (op >= 4'd9 && op <= 4'd12);
`else
    return (op >= 4'd1 && op <= 4'd4);
`endif
  endfunction

  // Plain 64-bit arithmetic reference for every result-producing op.
  function automatic logic [63:0] model_result(input logic [3:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [63:0] acc);
    longint sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    res = acc;
    case (op)
      4'd1: res = sa * sb;
      4'd2: res = ua * ub;
      4'd3: if (b != 0) begin q = sa / sb; r = sa % sb; res = {r[31:0], q[31:0]}; end
      4'd4: if (b != 0) begin uq = ua / ub; ur = ua % ub; res = {ur[31:0], uq[31:0]}; end
      4'd9:  res = acc + (sa * sb);
      4'd10: res = acc + (ua * ub);
      4'd11: res = acc - (sa * sb);
      4'd12: res = acc - (ua * ub);
      default: ;
    endcase
    return res;
  endfunction

  // One clock cycle: check combinational outputs before the edge, advance the model, check state after.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic r);
    bit          exp_start;
    logic [31:0] exp_out;
    mdu_op = op; src_a = a; src_b = b; req = r;
    #1;
    exp_start = is_launch(op) && !r && (m_left == 0);
    exp_out   = (op == 4'd7) ? m_hi : (op == 4'd8) ? m_lo : 32'd0;
    checkOutput("start", {31'b0, start}, {31'b0, exp_start});
    checkOutput("mdu_out", mdu_out, exp_out);
    @(posedge clk);
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin m_hi = p_hi; m_lo = p_lo; end
    end else if (exp_start) begin
      {p_hi, p_lo} = model_result(op, a, b, {m_hi, m_lo});
      m_left = (op == 4'd3 || op == 4'd4) ? DC : MC;
    end else if (!r) begin
      if (op == 4'd5) m_hi = a;
      if (op == 4'd6) m_lo = a;
    end
    #1;
    checkOutput("busy", {31'b0, busy}, {31'b0, (m_left > 0)});
    checkOutput("hi", hi, m_hi);
    checkOutput("lo", lo, m_lo);
  endtask

  task automatic runOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    applyStimulus(op, a, b, 1'b0);
    for (int i = 0; i < DC + 2 && m_left > 0; i++) applyStimulus(4'd0, 32'd0, 32'd0, 1'b0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b0; mdu_op = 4'd0; src_a = 0; src_b = 0; req = 0;
    m_hi = 0; m_lo = 0; p_hi = 0; p_lo = 0; m_left = 0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_hi", hi, 32'd0);
    checkOutput("rst_lo", lo, 32'd0);
    #3 reset = 1'b1;
    @(posedge clk); #1;

    runOp(4'd1, 32'hFFFF_FFFE, 32'd3);
    checkOutput("mult_hi", hi, 32'hFFFF_FFFF);
    checkOutput("mult_lo", lo, 32'hFFFF_FFFA);
    runOp(4'd2, 32'hFFFF_FFFE, 32'd3);
    checkOutput("multu_hi", hi, 32'h0000_0002);
    checkOutput("multu_lo", lo, 32'hFFFF_FFFA);
    runOp(4'd3, 32'hFFFF_FFF9, 32'd2);
    checkOutput("div_lo", lo, 32'hFFFF_FFFD);
    checkOutput("div_hi", hi, 32'hFFFF_FFFF);
    runOp(4'd5, 32'h11, 32'd0);
    runOp(4'd6, 32'h22, 32'd0);
    runOp(4'd4, 32'd7, 32'd0);
    checkOutput("div0_hi", hi, 32'h11);
    checkOutput("div0_lo", lo, 32'h22);
    runOp(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    checkOutput("ovf_lo", lo, 32'h8000_0000);
    checkOutput("ovf_hi", hi, 32'd0);
    runOp(4'd5, 32'h1234_5678, 32'd0);
    applyStimulus(4'd7, 32'd0, 32'd0, 1'b0);
    checkOutput("mfhi_direct", mdu_out, 32'h1234_5678);
    applyStimulus(4'd6, 32'hDEAD_BEEF, 32'd0, 1'b1);
    applyStimulus(4'd1, 32'd9, 32'd9, 1'b1);
    applyStimulus(4'd3, 32'd100, 32'd7, 1'b0);
    for (int i = 0; i < DC; i++) applyStimulus(4'd1, 32'd5, 32'd5, (i % 2) == 0);
    checkOutput("div_req_lo", lo, 32'd14);
    checkOutput("div_req_hi", hi, 32'd2);

    // Asynchronous reset in the middle of a divide.
    applyStimulus(4'd3, 32'd1000, 32'd3, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(4'd0, 32'd0, 32'd0, 1'b0);
    #2 reset = 1'b0;
    #1;
    m_hi = 0; m_lo = 0; m_left = 0;
    checkOutput("arst_busy", {31'b0, busy}, 32'd0);
    checkOutput("arst_hi", hi, 32'd0);
    checkOutput("arst_lo", lo, 32'd0);
    @(posedge clk); #3 reset = 1'b1;
    @(posedge clk); #1;
    runOp(4'd1, 32'd3, 32'd4);
    checkOutput("post_rst_lo", lo, 32'd12);

`ifdef MDU_MACC_EN
    runOp(4'd5, 32'd0, 32'd0);
    runOp(4'd6, 32'hFFFF_FFFF, 32'd0);
    runOp(4'd10, 32'd1, 32'd1);
    checkOutput("maddu_hi", hi, 32'd1);
    checkOutput("maddu_lo", lo, 32'd0);
    runOp(4'd5, 32'd0, 32'd0);
    runOp(4'd6, 32'd0, 32'd0);
    runOp(4'd11, 32'd1, 32'd1);
    checkOutput("msub_hi", hi, 32'hFFFF_FFFF);
    checkOutput("msub_lo", lo, 32'hFFFF_FFFF);
`endif

    for (int i = 0; i < 400; i++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 15));
      applyStimulus(op, pick_operand(), pick_operand(), $urandom_range(0, 4) == 0);
    end
    runOp(4'd0, 32'd0, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
